lcd_msg_stream: RTL and testbench

LCD_MSG_STREAM -- requirements
Module: lcd_msg_stream

---
 rtl/lcd_msg_stream.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_msg_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_msg_stream.sv
// Formats an instruction (mnemonic, destination, signed value) into an LCD byte stream.
// Optional build macro LCD_MSG_LEADING_BLANK_EN shows leading zero digits as spaces.
module lcd_msg_stream #(
  parameter int unsigned VALUE_W = 16,
  parameter int unsigned DEST_W  = 4,
  parameter int unsigned DIGITS  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_opcode,
  input  logic [DEST_W-1:0]  in_dest,
  input  logic [VALUE_W-1:0] in_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_rs,
  output logic               out_last
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned MAX_LEN = 10 + DEST_W + DIGITS;
  localparam int unsigned IDX_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
  localparam logic [2:0]  OP_CLEAR = 3'd6;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t               state_q, state_d;
  logic [2:0]           opc_q, opc_d;
  logic [DEST_W-1:0]    dest_q, dest_d;
  logic                 neg_q, neg_d;
  logic [VALUE_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 out_valid_d, out_rs_d, out_last_d;
  logic [7:0]           out_data_d;

  logic [2:0]           b_opc;
  logic [IDX_W-1:0]     b_idx;
  logic [7:0]           b_data;
  logic                 b_rs, b_last;
  logic [39:0]          mn;
  int unsigned          p, m, j;
  logic [DIGITS-1:0]    blank;

  // One double-dabble correction: add 3 to every BCD digit that is 5 or more
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = b;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = 4'(b >> (4 * i));
      if (d >= 4'd5) r[4*i +: 4] = d + 4'd3;
    end
    return r;
  endfunction

`ifdef LCD_MSG_LEADING_BLANK_EN
  // blank[k] marks digit k (0 = most significant) as a leading zero; last digit never blanks
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int k = 0; k < int'(DIGITS) - 1; k++) begin
      if (4'(bcd_q >> (4 * (int'(DIGITS) - 1 - k))) != 4'd0) nz = 1'b1;
      blank[k] = ~nz;
    end
  end
`else
  assign blank = '0;
`endif

  // Byte that will be presented next: byte 0 when starting, idx+1 while emitting
  always_comb begin
    b_opc  = (state_q == IDLE) ? in_opcode : opc_q;
    b_idx  = (state_q == EMIT) ? idx_q + IDX_W'(1) : '0;
    p      = 32'(b_idx);
    b_data = 8'h00;
    b_rs   = 1'b1;
    b_last = 1'b0;
    j      = 0;
    case (b_opc)
      3'd0:    begin mn = 40'("LOAD");  m = 4; end
      3'd1:    begin mn = 40'("ADD");   m = 3; end
      3'd2:    begin mn = 40'("ADDI");  m = 4; end
      3'd3:    begin mn = 40'("SUB");   m = 3; end
      3'd4:    begin mn = 40'("SUBI");  m = 4; end
      3'd5:    begin mn = 40'("MUL");   m = 3; end
      3'd6:    begin mn = 40'("CLEAR"); m = 5; end
      default: begin mn = 40'("DPL");   m = 3; end
    endcase
    if (b_opc == OP_CLEAR) begin
      if (p < m) b_data = 8'(mn >> (8 * (m - 1 - p)));
      else begin b_data = 8'h02; b_rs = 1'b0; b_last = 1'b1; end
    end else if (p < m) begin
      b_data = 8'(mn >> (8 * (m - 1 - p)));
    end else if (p == m) begin
      b_data = 8'h89; b_rs = 1'b0;
    end else if (p == m + 1) begin
      b_data = 8'h5B;
    end else if (p < m + 2 + DEST_W) begin
      b_data = 1'(dest_q >> (DEST_W - 1 - (p - m - 2))) ? 8'h31 : 8'h30;
    end else if (p == m + 2 + DEST_W) begin
      b_data = 8'h5D;
    end else if (p == m + 3 + DEST_W) begin
      b_data = 8'hC9; b_rs = 1'b0;
    end else if (p == m + 4 + DEST_W) begin
      b_data = neg_q ? 8'h2D : 8'h2B;
    end else if (p < m + 5 + DEST_W + DIGITS) begin
      j      = p - (m + 5 + DEST_W);
      b_data = blank[j] ? 8'h20 : {4'h3, 4'(bcd_q >> (4 * (DIGITS - 1 - j)))};
    end else begin
      b_data = 8'h02; b_rs = 1'b0; b_last = 1'b1;
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    dest_d      = dest_q;
    neg_d       = neg_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_rs_d    = out_rs;
    out_last_d  = out_last;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          opc_d  = in_opcode;
          dest_d = in_dest;
          neg_d  = in_value[VALUE_W-1];
          bin_d  = in_value[VALUE_W-1] ? (~in_value + VALUE_W'(1)) : in_value;
          bcd_d  = '0;
          cnt_d  = '0;
          idx_d  = '0;
          if (in_opcode == OP_CLEAR) begin
            state_d     = EMIT;
            out_valid_d = 1'b1;
            out_data_d  = b_data;
            out_rs_d    = b_rs;
            out_last_d  = b_last;
          end else begin
            state_d = CONV;
          end
        end
      end
      CONV: begin
        bcd_d = {dd_adjust(bcd_q)[BCD_W-2:0], bin_q[VALUE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VALUE_W - 1)) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_data_d  = b_data;
          out_rs_d    = b_rs;
          out_last_d  = b_last;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_rs_d    = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = b_idx;
            out_data_d = b_data;
            out_rs_d   = b_rs;
            out_last_d = b_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      opc_q     <= '0;
      dest_q    <= '0;
      neg_q     <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_rs    <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      dest_q    <= dest_d;
      neg_q     <= neg_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_rs    <= out_rs_d;
      out_last  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_lcd_msg_stream.sv
// Scoreboard bench for lcd_msg_stream: random instructions and back-pressure
// checked against a string/arithmetic message model.
module tb_lcd_msg_stream;
  localparam int unsigned VALUE_W = 16;
  localparam int unsigned DEST_W  = 4;
  localparam int unsigned DIGITS  = 5;
`ifdef LCD_MSG_LEADING_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic               clk, rst, in_valid, in_ready, out_valid, out_ready, out_rs, out_last;
  logic [2:0]         in_opcode;
  logic [DEST_W-1:0]  in_dest;
  logic [VALUE_W-1:0] in_value;
  logic [7:0]         out_data;

  lcd_msg_stream #(.VALUE_W(VALUE_W), .DEST_W(DEST_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rs(out_rs), .out_last(out_last)
  );

  logic [9:0] exp_q[$];   // {last, rs, data}
  int         acc_q[$];
  int         lat_q[$];
  int         n_vec = 0, n_err = 0, cyc = 0, byte_cnt = 0;
  bit         mon_en = 1'b1, msg_start = 1'b1, stall_pending = 1'b0;
  logic [9:0] held;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b0;
    forever begin @(posedge clk); #1; out_ready = ($urandom % 4) != 0; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference message built from the text rules with plain string/decimal arithmetic
  task automatic push_msg(input logic [2:0] op, input logic [DEST_W-1:0] dest, input logic [VALUE_W-1:0] val);
    string  mn;
    longint mag;
    int     d[DIGITS];
    bit     lead;
    case (op)
      3'd0: mn = "LOAD";  3'd1: mn = "ADD";  3'd2: mn = "ADDI"; 3'd3: mn = "SUB";
      3'd4: mn = "SUBI";  3'd5: mn = "MUL";  3'd6: mn = "CLEAR"; default: mn = "DPL";
    endcase
    for (int k = 0; k < mn.len(); k++) exp_q.push_back({2'b01, mn[k]});
    if (op != 3'd6) begin
      exp_q.push_back({2'b00, 8'h89});
      exp_q.push_back({2'b01, "["});
      for (int k = DEST_W - 1; k >= 0; k--) exp_q.push_back({2'b01, dest[k] ? "1" : "0"});
      exp_q.push_back({2'b01, "]"});
      exp_q.push_back({2'b00, 8'hC9});
      exp_q.push_back({2'b01, val[VALUE_W-1] ? "-" : "+"});
      mag = val[VALUE_W-1] ? (longint'(1) << VALUE_W) - longint'(val) : longint'(val);
      for (int k = DIGITS - 1; k >= 0; k--) begin d[k] = int'(mag % 10); mag = mag / 10; end
      lead = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (d[k] != 0) lead = 1'b0;
        if (BLANK_EN && lead && k < DIGITS - 1) exp_q.push_back({2'b01, 8'h20});
        else exp_q.push_back({2'b01, 8'(8'h30 + d[k])});
      end
    end
    exp_q.push_back({2'b10, 8'h02});
  endtask

  // Called at a negedge; drives garbage while busy, then issues the instruction
  task automatic send(input logic [2:0] op, input logic [DEST_W-1:0] dest, input logic [VALUE_W-1:0] val);
    int n = 0;
    while (!in_ready) begin
      in_valid = 1'($urandom); in_opcode = 3'($urandom); in_dest = DEST_W'($urandom); in_value = VALUE_W'($urandom);
      @(negedge clk);
      n++;
      if (n > 3000) begin chk("accept_timeout", 32'(in_ready), 32'd1); return; end
    end
    in_valid = 1'b1; in_opcode = op; in_dest = dest; in_value = val;
    acc_q.push_back(cyc);
    lat_q.push_back(op == 3'd6 ? 1 : VALUE_W + 1);
    push_msg(op, dest, val);
    @(negedge clk);
    in_valid = 1'($urandom); in_opcode = 3'($urandom); in_dest = DEST_W'($urandom); in_value = VALUE_W'($urandom);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks latency and stall stability
  always @(negedge clk) begin
    if (!mon_en) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        chk("stall_hold", 32'({out_valid, out_last, out_rs, out_data}), 32'({1'b1, held}));
        stall_pending = 1'b0;
      end
      if (out_valid && msg_start) begin
        if (acc_q.size() == 0) chk("unexpected_message", 32'(out_valid), 32'd0);
        else chk("first_byte_latency", 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front()));
        msg_start = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'({out_last, out_rs, out_data}), 32'h3ff);
        else chk("lcd_byte", 32'({out_last, out_rs, out_data}), 32'(exp_q.pop_front()));
        byte_cnt++;
        if (out_last) begin msg_start = 1'b1; byte_cnt = 0; end
      end else if (out_valid) begin
        held = {out_last, out_rs, out_data};
        stall_pending = 1'b1;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_dest = '0; in_value = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_rs_last", 32'({out_rs, out_last}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    send(3'd0, 4'b0101, 16'd1234);
    send(3'd1, 4'b1111, 16'h8000);
    send(3'd6, 4'($urandom), 16'($urandom));
    send(3'd4, 4'b0011, 16'd0);
    send(3'd2, 4'b0000, 16'h7fff);
    send(3'd3, 4'b1000, 16'hffff);

    // Abort a MUL message mid-stream with reset
    send(3'd5, 4'b0110, 16'($urandom));
    in_valid = 1'b0;
    n = 0;
    while (byte_cnt < 7 && n < 3000) begin @(negedge clk); n++; end
    chk("mul_progress", 32'(byte_cnt >= 7), 32'd1);
    mon_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_last", 32'(out_last), 32'd0);
    exp_q.delete(); acc_q.delete(); lat_q.delete();
    msg_start = 1'b1; byte_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_stays_idle", 32'(out_valid), 32'd0);
    mon_en = 1'b1;
    send(3'd7, 4'b1010, 16'hfb2e);

    for (int i = 0; i < 40; i++) begin
      logic [VALUE_W-1:0] v;
      case ($urandom % 6)
        0: v = '0;
        1: v = 16'h8000;
        2: v = 16'h7fff;
        3: v = 16'hffff;
        default: v = VALUE_W'($urandom);
      endcase
      send(3'($urandom), DEST_W'($urandom), v);
    end

    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin @(negedge clk); n++; end
    chk("drain_pending_bytes", 32'(exp_q.size()), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
